// File: rtl/sl_rx_ctrl.sv
// SL receiver controller: arms the asynchronous SL receiver and synchronises its
// ready/valid flags into clk. Completed words are right-aligned and queued in a
// small FIFO, then offered downstream with a valid/ready handshake. Bad frames
// and FIFO overflows are counted for the bridge.
module sl_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ARM_CYCLES  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [1:0]                    cfg_mode,
  input  logic                          clr_status,
  output logic                          rx_reset_n,
  output logic [1:0]                    rx_mode,
  input  logic [31:0]                   rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    err_cnt,
  output logic                          overflow,
  output logic                          cfg_err,
  output logic                          busy
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ARM_CYCLES + 1);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ARM = 2'd1,
    S_RUN = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_arm_cnt;
  logic                   r_rx_reset_n;
  logic [1:0]             r_rx_mode;
  logic                   r_cfg_err;
  logic                   r_busy;

  logic [SYNC_STAGES-1:0] r_ready_sync;
  logic [SYNC_STAGES-1:0] r_valid_sync;
  logic                   r_ready_d;

  logic [31:0]            r_mem [FIFO_DEPTH];
  logic [LW-1:0]          r_wptr;
  logic [LW-1:0]          r_rptr;
  logic [LW:0]            r_level;
  logic [7:0]             r_err_cnt;
  logic                   r_overflow;

  logic                   w_ready_s;
  logic                   w_valid_s;
  logic                   w_event;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic [31:0]            w_word;

  // Configuration FSM: OFF -> ARM (receiver held in reset) -> RUN, with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_OFF;
      r_arm_cnt    <= '0;
      r_rx_reset_n <= 1'b0;
      r_rx_mode    <= 2'd0;
      r_cfg_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      r_cfg_err <= cfg_enable && (cfg_mode == 2'd3);
      case (r_state)
        S_OFF: begin
          if (cfg_enable && (cfg_mode != 2'd3)) begin
            r_state   <= S_ARM;
            r_rx_mode <= cfg_mode;
            r_arm_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_ARM: begin
          if (!cfg_enable) begin
            r_state <= S_OFF;
            r_busy  <= 1'b0;
          end else if (r_arm_cnt == CW'(ARM_CYCLES - 1)) begin
            r_state      <= S_RUN;
            r_rx_reset_n <= 1'b1;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!cfg_enable || (cfg_mode == 2'd3)) begin
            r_state      <= S_OFF;
            r_rx_reset_n <= 1'b0;
            r_busy       <= 1'b0;
          end else if (cfg_mode != r_rx_mode) begin
            r_state      <= S_ARM;
            r_rx_mode    <= cfg_mode;
            r_arm_cnt    <= '0;
            r_rx_reset_n <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_OFF;
          r_rx_reset_n <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Synchronise receiver flags into clk and keep the previous ready for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_sync <= '0;
      r_valid_sync <= '0;
      r_ready_d    <= 1'b0;
    end else begin
      r_ready_sync <= {r_ready_sync[SYNC_STAGES-2:0], rx_ready};
      r_valid_sync <= {r_valid_sync[SYNC_STAGES-2:0], rx_valid};
      r_ready_d    <= w_ready_s;
    end
  end

  assign w_ready_s = r_ready_sync[SYNC_STAGES-1];
  assign w_valid_s = r_valid_sync[SYNC_STAGES-1];
  // Edges seen outside RUN still update r_ready_d, so they are consumed and ignored.
  assign w_event   = w_ready_s && !r_ready_d && (r_state == S_RUN);

  // Right-align the received word according to the active word length
  always_comb begin
    // NOTE: default first so every path assigns w_word and no latch is inferred.
    w_word = rx_data;
    case (r_rx_mode)
      2'd0:    w_word = {24'h0, rx_data[31:24]};
      2'd1:    w_word = {16'h0, rx_data[31:16]};
      default: w_word = rx_data;
    endcase
  end

  assign w_full = (r_level == (LW + 1)'(FIFO_DEPTH));
  assign w_pop  = (r_level != '0) && out_ready;
  assign w_push = w_event && w_valid_s && (!w_full || w_pop);

  // FIFO storage written on accepted pushes
  // NOTE: the storage array has no reset; the level counter alone defines which
  // entries are meaningful, and out_data is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // FIFO pointers, level and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_err_cnt  <= 8'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Clearing takes priority over a same-cycle increment or set.
      if (clr_status) begin
        r_err_cnt  <= 8'd0;
        r_overflow <= 1'b0;
      end else begin
        if (w_event && !w_valid_s && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 1'b1;
        if (w_event && w_valid_s && w_full && !w_pop)      r_overflow <= 1'b1;
      end
    end
  end

  assign out_data   = (r_level != '0) ? r_mem[r_rptr] : 32'h0;
  assign out_valid  = (r_level != '0);
  assign fifo_level = r_level;
  assign err_cnt    = r_err_cnt;
  assign overflow   = r_overflow;
  assign rx_reset_n = r_rx_reset_n;
  assign rx_mode    = r_rx_mode;
  assign cfg_err    = r_cfg_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Self-checking bench for sl_rx_ctrl: drives the receiver side directly and keeps
// a scoreboard queue of expected words, compared as they are popped downstream.
module tb_sl_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int ARM   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        clr_status = 1'b0;
  logic        rx_reset_n;
  logic [1:0]  rx_mode;
  logic [31:0] rx_data = 32'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic [7:0]  err_cnt;
  logic        overflow;
  logic        cfg_err;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q [$];
  int          m_level = 0;
  logic        m_overflow = 1'b0;
  int          m_err = 0;

  sl_rx_ctrl #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .ARM_CYCLES(ARM)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_enable (cfg_enable),
    .cfg_mode   (cfg_mode),
    .clr_status (clr_status),
    .rx_reset_n (rx_reset_n),
    .rx_mode    (rx_mode),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .err_cnt    (err_cnt),
    .overflow   (overflow),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [1:0] mode, input logic [31:0] d);
    case (mode)
      2'd0:    return {24'h0, d[31:24]};
      2'd1:    return {16'h0, d[31:16]};
      default: return d;
    endcase
  endfunction

  // Enable in the given mode and wait (bounded) until the receiver is released.
  task automatic configure(input logic [1:0] mode);
    int n;
    cfg_mode   = mode;
    cfg_enable = 1'b1;
    @(negedge clk);
    n = 0;
    while (rx_reset_n !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("arm_released", {31'h0, rx_reset_n}, 32'h1);
    check("busy_run", {31'h0, busy}, 32'h1);
  endtask

  // One receiver word: data/valid settle, ready rises, held, then falls.
  task automatic send_word(input logic [31:0] d, input logic v, input logic [1:0] mode);
    bit was_empty;
    bit seen;
    int lat;
    was_empty = (m_level == 0);
    seen      = 1'b0;
    lat       = 0;
    rx_data   = d;
    rx_valid  = v;
    @(negedge clk);
    rx_ready = 1'b1;
    if (v) begin
      if (m_level < DEPTH) begin
        sb_q.push_back(align(mode, d));
        m_level++;
      end else begin
        m_overflow = 1'b1;
      end
    end else if (m_err < 255) begin
      m_err++;
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!seen && out_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (v && was_empty)
      check("latency_ok", 32'(seen && lat <= SYNC + 2), 32'h1);
    rx_ready = 1'b0;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Wait (bounded) for a head word, compare it with the scoreboard, then pop it.
  task automatic pop_check(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%08h expected no word (scoreboard empty)", tag, out_data);
    end else begin
      check(tag, out_data, sb_q.pop_front());
      m_level--;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low;
    bit busy_ok;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_reset_n", {31'h0, rx_reset_n}, 32'h0);
    check("rst_rx_mode",    {30'h0, rx_mode},    32'h0);
    check("rst_out_valid",  {31'h0, out_valid},  32'h0);
    check("rst_out_data",   out_data,            32'h0);
    check("rst_level",      {29'h0, fifo_level}, 32'h0);
    check("rst_err_cnt",    {24'h0, err_cnt},    32'h0);
    check("rst_overflow",   {31'h0, overflow},   32'h0);
    check("rst_busy",       {31'h0, busy},       32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8-bit word right-aligned, lower junk discarded
    configure(2'd0);
    send_word(32'hA53C5A0F, 1'b1, 2'd0);
    check("t1_level", {29'h0, fifo_level}, 32'(m_level));
    check("t1_valid", {31'h0, out_valid},  32'h1);
    check("t1_head",  out_data,            32'h000000A5);
    pop_check("t1_pop");
    check("t1_empty", {31'h0, out_valid},  32'h0);

    // 32-bit and 16-bit words
    configure(2'd2);
    send_word(32'hDEADBEEF, 1'b1, 2'd2);
    pop_check("t2_word32");
    configure(2'd1);
    send_word(32'h1234ABCD, 1'b1, 2'd1);
    pop_check("t2_word16");

    // Bad frame counted, not pushed; clr_status clears the count
    send_word(32'hFFFF0000, 1'b0, 2'd1);
    check("t3_err_cnt", {24'h0, err_cnt},    32'(m_err));
    check("t3_level",   {29'h0, fifo_level}, 32'(m_level));
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    m_err = 0;
    check("t3_err_clr", {24'h0, err_cnt}, 32'(m_err));

    // Overflow: DEPTH+1 words with downstream stalled
    for (int i = 0; i < DEPTH + 1; i++)
      send_word({16'(16'h0100 + i), 16'hCAFE}, 1'b1, 2'd1);
    check("t4_level",    {29'h0, fifo_level}, 32'(m_level));
    check("t4_overflow", {31'h0, overflow},   {31'h0, m_overflow});
    for (int i = 0; i < DEPTH; i++)
      pop_check("t4_order");
    check("t4_sticky", {31'h0, overflow}, 32'h1);
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    m_overflow = 1'b0;
    check("t4_ovf_clr", {31'h0, overflow}, {31'h0, m_overflow});

    // Mode change in RUN re-arms for exactly ARM cycles with busy held
    configure(2'd0);
    cfg_mode = 2'd1;
    n_low    = 0;
    busy_ok  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (rx_reset_n === 1'b0) n_low++;
      else if (n_low > 0) break;
    end
    check("t5_arm_low",  32'(n_low),       32'(ARM));
    check("t5_busy",     32'(busy_ok),     32'h1);
    check("t5_rx_mode",  {30'h0, rx_mode}, 32'h1);
    cfg_mode = 2'd3;
    repeat (2) @(negedge clk);
    check("t5_ill_rstn", {31'h0, rx_reset_n}, 32'h0);
    check("t5_cfg_err",  {31'h0, cfg_err},    32'h1);
    check("t5_ill_busy", {31'h0, busy},       32'h0);

    // Reset mid-word with two words queued
    configure(2'd0);
    send_word(32'h11000000, 1'b1, 2'd0);
    send_word(32'h22000000, 1'b1, 2'd0);
    check("t6_queued", {29'h0, fifo_level}, 32'(m_level));
    rx_data  = 32'h33000000;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_level",     {29'h0, fifo_level}, 32'h0);
    check("t6_valid",     {31'h0, out_valid},  32'h0);
    check("t6_data",      out_data,            32'h0);
    check("t6_rx_reset_n",{31'h0, rx_reset_n}, 32'h0);
    check("t6_busy",      {31'h0, busy},       32'h0);
    check("t6_rx_mode",   {30'h0, rx_mode},    32'h0);
    rx_ready = 1'b0;
    rx_valid = 1'b0;
    sb_q.delete();
    m_level = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_partial", {29'h0, fifo_level}, 32'(m_level));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
